bram_sdp_be: RTL

Parametrised simple-dual-port block RAM with per-lane write enables, a selectable read-during-write policy, an optional output pipeline register and a read-valid flag. It supersedes the fixed-shape single-cycle SDP wrappers as the generic BRAM primitive for the qlf_k6n10f flow. One port only writes and the other only reads. Both ports run on a single clock. The read path has an asynchronous reset, so downstream logic sees clean valid/data after reset.

---
 rtl/bram_sdp_pkg.sv | 28 ++
 rtl/bram_sdp_core.sv | 42 ++++
 rtl/bram_sdp_be.sv | 110 +++++++++++
 3 files changed

// File: rtl/bram_sdp_pkg.sv
// Shared constants and parameter helpers for the lane-enabled
// simple-dual-port block RAM.
package bram_sdp_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  function automatic int nlanes(
    input int dwidth,
    input int lane_w
  );
    return dwidth / lane_w;
  endfunction

  function automatic bit params_ok(
    input int dwidth,
    input int lane_w,
    input int out_reg,
    input int rdw_mode
  );
    return (lane_w > 0)
        && (dwidth > 0)
        && (dwidth % lane_w == 0)
        && (out_reg inside {0, 1})
        && (rdw_mode inside {0, 1});
  endfunction

endpackage

// File: rtl/bram_sdp_core.sv
// Storage array with lane-masked write and raw synchronous read.
// Kept reset-free so synthesis maps it onto a block RAM.
module bram_sdp_core
  import bram_sdp_pkg::*;
#(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 36,
  parameter int LANE_W = 9
) (
  input  logic                       clk,
  input  logic                       rce,
  input  logic [AWIDTH-1:0]          ra,
  output logic [DWIDTH-1:0]          rdata,
  input  logic                       wce,
  input  logic [AWIDTH-1:0]          wa,
  input  logic [DWIDTH/LANE_W-1:0]   wbe,
  input  logic [DWIDTH-1:0]          wd
);

  localparam int NL    = nlanes(DWIDTH, LANE_W);
  localparam int DEPTH = 2 ** AWIDTH;

  // Power-up contents are all zero; reset never touches the array.
  logic [DWIDTH-1:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (wce) begin
      for (int i = 0; i < NL; i++) begin
        if (wbe[i]) begin
          mem[wa][i*LANE_W +: LANE_W] <= wd[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rce) begin
      rdata <= mem[ra];
    end
  end

endmodule

// File: rtl/bram_sdp_be.sv
// Simple-dual-port BRAM with lane write enables, selectable
// read-during-write policy, optional output register and read valid.
module bram_sdp_be
  import bram_sdp_pkg::*;
#(
  parameter int AWIDTH   = 10,
  parameter int DWIDTH   = 36,
  parameter int LANE_W   = 9,
  parameter int OUT_REG  = 0,
  parameter int RDW_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rce,
  input  logic [AWIDTH-1:0]        ra,
  output logic [DWIDTH-1:0]        rq,
  output logic                     rvalid,
  input  logic                     wce,
  input  logic [AWIDTH-1:0]        wa,
  input  logic [DWIDTH/LANE_W-1:0] wbe,
  input  logic [DWIDTH-1:0]        wd
);

  localparam int NL = nlanes(DWIDTH, LANE_W);

  if (!params_ok(DWIDTH, LANE_W, OUT_REG, RDW_MODE)) begin : g_bad
    $error("bram_sdp_be: illegal parameter combination");
  end

  logic              rd_en;
  logic              wr_en;
  logic              hit;
  logic [DWIDTH-1:0] raw;
  logic [DWIDTH-1:0] be_mask;
  logic [DWIDTH-1:0] byp_mask;
  logic [DWIDTH-1:0] byp_data;
  logic [DWIDTH-1:0] s1_data;
  logic              s1_valid;
  logic              s1_clr;

  assign rd_en = rce & ~rst;
  assign wr_en = wce & ~rst;

  for (genvar i = 0; i < NL; i++) begin : g_lane
    assign be_mask[i*LANE_W +: LANE_W] = {LANE_W{wbe[i]}};
  end

  bram_sdp_core #(
    .AWIDTH (AWIDTH),
    .DWIDTH (DWIDTH),
    .LANE_W (LANE_W)
  ) u_core (
    .clk   (clk),
    .rce   (rd_en),
    .ra    (ra),
    .rdata (raw),
    .wce   (wr_en),
    .wa    (wa),
    .wbe   (wbe),
    .wd    (wd)
  );

  assign hit = (RDW_MODE == RDW_WRITE_FIRST)
            && wce && (ra == wa);

  // s1_clr masks the reset-free array output until the first
  // read after reset, so S1 data reads as zero in the meantime.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_clr   <= 1'b1;
      byp_mask <= '0;
      byp_data <= '0;
    end else begin
      s1_valid <= rce;
      if (rce) begin
        s1_clr   <= 1'b0;
        byp_mask <= hit ? be_mask : '0;
        byp_data <= wd;
      end
    end
  end

  assign s1_data = s1_clr ? '0
                 : (raw & ~byp_mask) | (byp_data & byp_mask);

  if (OUT_REG != 0) begin : g_oreg
    logic [DWIDTH-1:0] s2_data;
    logic              s2_valid;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_data  <= '0;
        s2_valid <= 1'b0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= s1_data;
        end
      end
    end

    assign rq     = s2_data;
    assign rvalid = s2_valid;
  end else begin : g_direct
    assign rq     = s1_data;
    assign rvalid = s1_valid;
  end

endmodule
